// File: rtl/cpu_pkg.sv
// Shared core constants: instruction memory geometry, NOP encoding and reset PC.
package cpu_pkg;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 12;
    localparam int RESET_PC   = 0;
    localparam logic [DATA_WIDTH-1:0] NOP = {DATA_WIDTH{1'b0}};
endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH x WIDTH circular FIFO with synchronous clear and occupancy count.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    // Callers never push when full or pop when empty; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata = mem[rd_ptr];
endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the PC, samples async imem data and buffers
// {pc, instr} pairs towards decode; redirect outranks pop, push and stall.
module instr_fetch #(
    parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cpu_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = 2,
    parameter int RESET_PC   = cpu_pkg::RESET_PC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_instr,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_instr,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic [15:0]           fetch_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         count;
    logic [EW-1:0]         head;
    logic                  full;
    logic                  push;
    logic                  pop;

    // Handshake: an entry transfers to decode on any edge where out_valid && out_ready
    // and no redirect is present; out_valid never drops and the head never changes
    // while waiting for out_ready, except on redirect or reset.
    assign full      = (count == CW'(FIFO_DEPTH));
    assign push      = !redirect && !stall && !full;
    assign pop       = out_valid && out_ready && !redirect;
    assign out_valid = (count != '0);
    assign imem_addr = pc;
    assign out_pc    = head[EW-1:DATA_WIDTH];
    assign out_instr = head[DATA_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc        <= ADDR_WIDTH'(RESET_PC);
            fetch_cnt <= '0;
        end else if (redirect) begin
            pc <= redirect_pc;
        end else begin
            if (push) pc <= pc + 1'b1;
            if (pop)  fetch_cnt <= fetch_cnt + 16'd1;
        end
    end

    fetch_fifo #(
        .DEPTH(FIFO_DEPTH),
        .WIDTH(EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (redirect),
        .push  (push),
        .pop   (pop),
        .wdata ({pc, imem_instr}),
        .rdata (head),
        .count (count)
    );
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed vector table for the corner cases, then random
// traffic compared against a queue-based reference of the fetch buffer.
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic                  clk;
    logic                  rst_n;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_instr;
    logic                  stall;
    logic                  redirect;
    logic [ADDR_WIDTH-1:0] redirect_pc;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0] out_pc;
    logic [15:0]           fetch_cnt;

    logic [DATA_WIDTH-1:0] imem [2**ADDR_WIDTH];
    assign imem_instr = imem[imem_addr];

    instr_fetch #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_pc     (out_pc),
        .fetch_cnt  (fetch_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } ent_t;

    ent_t                  m_q[$];
    logic [ADDR_WIDTH-1:0] m_pc;
    logic [15:0]           m_cnt;

    function automatic logic [DATA_WIDTH-1:0] image_word(input logic [ADDR_WIDTH-1:0] a);
        return 12'h100 + {4'h0, a};
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pc  = '0;
        m_cnt = '0;
    endtask

    // Applies one clock edge of the fetch rules to the model.
    task automatic model_step(input logic r_n, input logic st, input logic rd,
                              input logic [ADDR_WIDTH-1:0] rpc, input logic rdy);
        int  sz;
        ent_t e;
        if (!r_n) begin
            model_reset();
        end else if (rd) begin
            m_q.delete();
            m_pc = rpc;
        end else begin
            sz = m_q.size();
            if (sz > 0 && rdy) begin
                void'(m_q.pop_front());
                m_cnt++;
            end
            if (!st && sz < DEPTH) begin
                e.pc    = m_pc;
                e.instr = image_word(m_pc);
                m_q.push_back(e);
                m_pc++;
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic r_n, input logic st, input logic rd,
                         input logic [ADDR_WIDTH-1:0] rpc, input logic rdy);
        rst_n       = r_n;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        out_ready   = rdy;
    endtask

    // ---------------- directed vectors ----------------
    // Expected values are the outputs seen before the edge at which the inputs apply.
    typedef struct {
        logic                  rst_n;
        logic                  stall;
        logic                  redirect;
        logic [ADDR_WIDTH-1:0] rpc;
        logic                  ready;
        logic                  exp_valid;
        logic [ADDR_WIDTH-1:0] exp_pc;
        logic [DATA_WIDTH-1:0] exp_instr;
        logic [ADDR_WIDTH-1:0] exp_addr;
        logic [15:0]           exp_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r_n, input logic st, input logic rd,
                                input logic [7:0] rpc, input logic rdy, input logic v,
                                input logic [7:0] pc, input logic [11:0] ins,
                                input logic [7:0] addr, input logic [15:0] cnt);
        vec_t x;
        x.rst_n = r_n; x.stall = st; x.redirect = rd; x.rpc = rpc; x.ready = rdy;
        x.exp_valid = v; x.exp_pc = pc; x.exp_instr = ins; x.exp_addr = addr; x.exp_cnt = cnt;
        return x;
    endfunction

    vec_t vecs[21];

    initial begin
        logic st, rd, rdy, r_n;
        logic [ADDR_WIDTH-1:0] rpc;

        for (int k = 0; k < 2**ADDR_WIDTH; k++) imem[k] = 12'h100 + 12'(k);

        //            rst st rd rpc    rdy v  pc     instr    addr   cnt
        vecs[0]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 12'h000, 8'h00, 16'd0);
        vecs[1]  = mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 12'h100, 8'h01, 16'd0);
        vecs[2]  = mk(1, 0, 0, 8'h00, 0, 1, 8'h01, 12'h101, 8'h02, 16'd1);
        vecs[3]  = mk(1, 0, 0, 8'h00, 0, 1, 8'h01, 12'h101, 8'h03, 16'd1);
        vecs[4]  = mk(1, 0, 0, 8'h00, 0, 1, 8'h01, 12'h101, 8'h03, 16'd1);
        vecs[5]  = mk(1, 0, 1, 8'h40, 1, 1, 8'h01, 12'h101, 8'h03, 16'd1);
        vecs[6]  = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 12'h000, 8'h40, 16'd1);
        vecs[7]  = mk(1, 0, 0, 8'h00, 1, 1, 8'h40, 12'h140, 8'h41, 16'd1);
        vecs[8]  = mk(1, 1, 0, 8'h00, 1, 1, 8'h41, 12'h141, 8'h42, 16'd2);
        vecs[9]  = mk(1, 1, 0, 8'h00, 1, 0, 8'h00, 12'h000, 8'h42, 16'd3);
        vecs[10] = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 12'h000, 8'h42, 16'd3);
        vecs[11] = mk(1, 0, 0, 8'h00, 1, 1, 8'h42, 12'h142, 8'h43, 16'd3);
        vecs[12] = mk(1, 0, 1, 8'hFE, 1, 1, 8'h43, 12'h143, 8'h44, 16'd4);
        vecs[13] = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 12'h000, 8'hFE, 16'd4);
        vecs[14] = mk(1, 0, 0, 8'h00, 1, 1, 8'hFE, 12'h1FE, 8'hFF, 16'd4);
        vecs[15] = mk(1, 0, 0, 8'h00, 1, 1, 8'hFF, 12'h1FF, 8'h00, 16'd5);
        vecs[16] = mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 12'h100, 8'h01, 16'd6);
        vecs[17] = mk(1, 0, 0, 8'h00, 0, 1, 8'h01, 12'h101, 8'h02, 16'd7);
        vecs[18] = mk(0, 0, 0, 8'h00, 0, 1, 8'h01, 12'h101, 8'h03, 16'd7);
        vecs[19] = mk(1, 0, 0, 8'h00, 1, 0, 8'h00, 12'h000, 8'h00, 16'd0);
        vecs[20] = mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 12'h100, 8'h01, 16'd0);

        // Reset and check the reset state.
        drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_pc",    32'(out_pc),    32'd0);
        chk("reset out_instr", 32'(out_instr), 32'd0);
        chk("reset imem_addr", 32'(imem_addr), 32'd0);
        chk("reset fetch_cnt", 32'(fetch_cnt), 32'd0);
        model_reset();

        // Directed table: backpressure, redirect, stall, wrap, reset mid-run.
        for (int i = 0; i < 21; i++) begin
            if (i != 0) @(negedge clk);
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
            chk($sformatf("vec%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d out_pc", i),    32'(out_pc),    32'(vecs[i].exp_pc));
                chk($sformatf("vec%0d out_instr", i), 32'(out_instr), 32'(vecs[i].exp_instr));
            end
            chk($sformatf("vec%0d imem_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
            chk($sformatf("vec%0d fetch_cnt", i), 32'(fetch_cnt), 32'(vecs[i].exp_cnt));
            @(posedge clk);
            model_step(vecs[i].rst_n, vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].ready);
        end

        // Sustained streaming: ten accepts in ten consecutive cycles.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
            chk("stream out_valid", 32'(out_valid), 32'd1);
            chk("stream out_pc",    32'(out_pc),    32'(i + 1));
            @(posedge clk);
            model_step(1'b1, 1'b0, 1'b0, '0, 1'b1);
        end
        @(negedge clk);
        chk("stream fetch_cnt", 32'(fetch_cnt), 32'd11);

        // Random traffic against the reference model.
        for (int i = 0; i < 2000; i++) begin
            if (i != 0) @(negedge clk);
            r_n = ($urandom_range(63) != 0);
            rd  = ($urandom_range(15) == 0);
            st  = ($urandom_range(3) == 0);
            rdy = ($urandom_range(3) != 0);
            rpc = ADDR_WIDTH'($urandom_range(255));
            drive(r_n, st, rd, rpc, rdy);
            chk("rand out_valid", 32'(out_valid), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("rand out_pc",    32'(out_pc),    32'(m_q[0].pc));
                chk("rand out_instr", 32'(out_instr), 32'(m_q[0].instr));
            end
            chk("rand imem_addr", 32'(imem_addr), 32'(m_pc));
            chk("rand fetch_cnt", 32'(fetch_cnt), 32'(m_cnt));
            @(posedge clk);
            model_step(r_n, st, rd, rpc, rdy);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
